// File: rtl/lcd_timing_gen.sv
// Raster timing generator: pixel/line counters with HSYNC, VSYNC, DE and FrameStart decode.
// Optional completed-frame counter on FrameCount is built only when LCD_TIMING_FRAME_COUNT_EN is defined.
module lcd_timing_gen #(
    parameter int unsigned H_PULSE  = 1,
    parameter int unsigned H_BP     = 182,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 210,
    parameter int unsigned V_PULSE  = 5,
    parameter int unsigned V_BP     = 6,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 62
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        LCD_EN,
    output logic [15:0] PixelCount,
    output logic [15:0] LineCount,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic        LCD_DE,
    output logic        FrameStart,
    output logic [15:0] FrameCount
);

    localparam logic [15:0] H_LAST  = 16'(H_PULSE + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [15:0] V_LAST  = 16'(V_PULSE + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [15:0] HS_END  = 16'(H_PULSE);
    localparam logic [15:0] VS_END  = 16'(V_PULSE);
    localparam logic [15:0] DE_X0   = 16'(H_PULSE + H_BP);
    localparam logic [15:0] DE_X1   = 16'(H_PULSE + H_BP + H_ACTIVE);
    localparam logic [15:0] DE_Y0   = 16'(V_PULSE + V_BP);
    localparam logic [15:0] DE_Y1   = 16'(V_PULSE + V_BP + V_ACTIVE);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] px_q, px_d;
    logic [15:0] ln_q, ln_d;
    logic        running;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            px_q    <= '0;
            ln_q    <= '0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            ln_q    <= ln_d;
        end
    end

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        ln_d    = ln_q;
        case (state_q)
            ST_IDLE: begin
                // The first enabled edge only arms the raster; counting starts one edge later.
                px_d = '0;
                ln_d = '0;
                if (LCD_EN) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!LCD_EN) begin
                    state_d = ST_IDLE;
                    px_d    = '0;
                    ln_d    = '0;
                end else if (px_q == H_LAST) begin
                    px_d = '0;
                    ln_d = (ln_q == V_LAST) ? '0 : ln_q + 16'd1;
                end else begin
                    px_d = px_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                px_d    = '0;
                ln_d    = '0;
            end
        endcase
    end

    assign running    = (state_q == ST_RUN);
    assign PixelCount = px_q;
    assign LineCount  = ln_q;
    assign LCD_HSYNC  = !(running && (px_q < HS_END));
    assign LCD_VSYNC  = !(running && (ln_q < VS_END));
    assign LCD_DE     = running && (px_q >= DE_X0) && (px_q < DE_X1)
                                && (ln_q >= DE_Y0) && (ln_q < DE_Y1);
    assign FrameStart = running && (px_q == '0) && (ln_q == '0);

`ifdef LCD_TIMING_FRAME_COUNT_EN
    logic [15:0] fc_q, fc_d;
    logic        frame_wrap;

    // The wrap edge is the one that takes (H_LAST,V_LAST) back to (0,0) while still enabled.
    assign frame_wrap = running && LCD_EN && (px_q == H_LAST) && (ln_q == V_LAST);

    always_comb begin
        fc_d = fc_q;
        if (frame_wrap) fc_d = fc_q + 16'd1;
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) fc_q <= '0;
        else       fc_q <= fc_d;
    end

    assign FrameCount = fc_q;
`else
    assign FrameCount = '0;
`endif

endmodule
